// File: rtl/i2s_rx_deserializer.sv
// Philips I2S receiver: oversamples bclk/lrclk/sd on clk, deserializes stereo slots and qualifies lock.
// Optional bclk-loss timeout is built in when KOSEI_I2S_RX_TIMEOUT_EN is defined.
module i2s_rx_deserializer #(
  parameter int unsigned DATA_W      = 24,
  parameter int unsigned LOCK_FRAMES = 4,
  parameter int unsigned MIN_SLOT    = 16,
  parameter int unsigned MAX_SLOT    = 32,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i2s_bclk,
  input  logic              i2s_lrclk,
  input  logic              i2s_sd,
  output logic              pcm_valid,
  output logic [DATA_W-1:0] pcm_l,
  output logic [DATA_W-1:0] pcm_r,
  output logic              locked,
  output logic              frame_err,
  output logic              rx_timeout
);

  localparam int unsigned    LCW      = $clog2(LOCK_FRAMES + 1);
  localparam logic [5:0]     DATA_W_C = 6'(DATA_W);
  localparam logic [5:0]     MIN_C    = 6'(MIN_SLOT);
  localparam logic [5:0]     MAX_C    = 6'(MAX_SLOT);
  localparam logic [LCW-1:0] LOCK_C   = LCW'(LOCK_FRAMES);

  if (DATA_W < 2 || DATA_W > 63 || MIN_SLOT > MAX_SLOT || MAX_SLOT > 63 ||
      LOCK_FRAMES < 1 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65536) begin : g_param_check
    $error("i2s_rx_deserializer: illegal parameter set");
  end

  typedef enum logic {SEARCH, RUN} state_e;

  logic [1:0]        bclk_sync_q, lr_sync_q, sd_sync_q;
  logic              bclk_d_q;
  logic              bclk_rise;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] pcm_l_q, pcm_l_d, pcm_r_q, pcm_r_d;
  logic [5:0]        bit_cnt_q, bit_cnt_d;
  logic [LCW-1:0]    lock_cnt_q, lock_cnt_d;
  logic              started_q, started_d;
  logic              lr_prev_q, lr_prev_d;
  logic              locked_q, locked_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              to_fire;

  logic [DATA_W-1:0] shift_in, word;
  logic [5:0]        cnt_inc;
  logic [LCW-1:0]    lock_nxt;

  assign bclk_rise = bclk_sync_q[1] & ~bclk_d_q;

`ifdef KOSEI_I2S_RX_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
  localparam logic [15:0] TO_PRE  = 16'(TIMEOUT_CYC - 2);

  logic [15:0] to_cnt_q;
  logic        rx_to_q;

  // Counter parks at TO_LAST so a single outage yields a single pulse.
  assign to_fire = ~bclk_rise & (to_cnt_q == TO_PRE);

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_q <= '0;
      rx_to_q  <= 1'b0;
    end else begin
      rx_to_q <= to_fire;
      if (bclk_rise) begin
        to_cnt_q <= '0;
      end else if (to_cnt_q != TO_LAST) begin
        to_cnt_q <= to_cnt_q + 16'd1;
      end
    end
  end

  assign rx_timeout = rx_to_q;
`else
  assign to_fire    = 1'b0;
  assign rx_timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    hold_d     = hold_q;
    pcm_l_d    = pcm_l_q;
    pcm_r_d    = pcm_r_q;
    bit_cnt_d  = bit_cnt_q;
    lock_cnt_d = lock_cnt_q;
    started_d  = started_q;
    lr_prev_d  = lr_prev_q;
    locked_d   = locked_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    shift_in   = shift_q;
    cnt_inc    = bit_cnt_q;
    word       = '0;
    lock_nxt   = lock_cnt_q;

    if (bclk_rise) begin
      if (bit_cnt_q < DATA_W_C) begin
        shift_in = {shift_q[DATA_W-2:0], sd_sync_q[1]};
      end
      cnt_inc   = (bit_cnt_q == 6'd63) ? bit_cnt_q : bit_cnt_q + 6'd1;
      shift_d   = shift_in;
      bit_cnt_d = cnt_inc;

      // Philips delay: the boundary bit belongs to the old slot, so close the slot after shifting it.
      if (lr_sync_q[1] != lr_prev_q) begin
        word      = (cnt_inc < DATA_W_C) ? (shift_in << (DATA_W_C - cnt_inc)) : shift_in;
        shift_d   = '0;
        bit_cnt_d = '0;
        lr_prev_d = lr_sync_q[1];
        unique case (state_q)
          SEARCH: begin
            started_d = 1'b1;
            state_d   = RUN;
          end
          RUN: begin
            if (cnt_inc < MIN_C || cnt_inc > MAX_C) begin
              err_d      = 1'b1;
              lock_cnt_d = '0;
              locked_d   = 1'b0;
              state_d    = SEARCH;
            end else if (!lr_prev_q) begin
              hold_d = word;
            end else begin
              lock_nxt   = (lock_cnt_q == LOCK_C) ? lock_cnt_q : lock_cnt_q + 1'b1;
              lock_cnt_d = lock_nxt;
              if (locked_q || lock_nxt == LOCK_C) begin
                locked_d = 1'b1;
                valid_d  = 1'b1;
                pcm_l_d  = hold_q;
                pcm_r_d  = word;
              end
            end
          end
          default: state_d = SEARCH;
        endcase
      end
    end

    if (to_fire) begin
      locked_d   = 1'b0;
      lock_cnt_d = '0;
      state_d    = SEARCH;
      shift_d    = '0;
      bit_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bclk_sync_q <= '0;
      lr_sync_q   <= '0;
      sd_sync_q   <= '0;
      bclk_d_q    <= 1'b0;
      state_q     <= SEARCH;
      shift_q     <= '0;
      hold_q      <= '0;
      pcm_l_q     <= '0;
      pcm_r_q     <= '0;
      bit_cnt_q   <= '0;
      lock_cnt_q  <= '0;
      started_q   <= 1'b0;
      lr_prev_q   <= 1'b0;
      locked_q    <= 1'b0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[0], i2s_bclk};
      lr_sync_q   <= {lr_sync_q[0], i2s_lrclk};
      sd_sync_q   <= {sd_sync_q[0], i2s_sd};
      bclk_d_q    <= bclk_sync_q[1];
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      pcm_l_q     <= pcm_l_d;
      pcm_r_q     <= pcm_r_d;
      bit_cnt_q   <= bit_cnt_d;
      lock_cnt_q  <= lock_cnt_d;
      started_q   <= started_d;
      lr_prev_q   <= lr_prev_d;
      locked_q    <= locked_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  assign pcm_valid = valid_q;
  assign pcm_l     = pcm_l_q;
  assign pcm_r     = pcm_r_q;
  assign locked    = locked_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Randomized bench for i2s_rx_deserializer against a slot-level reference model.
// Timeout scenario is included when KOSEI_I2S_RX_TIMEOUT_EN is defined.
module tb_i2s_rx_deserializer;

  localparam int unsigned DW     = 24;
  localparam int unsigned TO_CYC = 1024;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i2s_bclk = 1'b0, i2s_lrclk = 1'b0, i2s_sd = 1'b0;
  logic          pcm_valid, locked, frame_err, rx_timeout;
  logic [DW-1:0] pcm_l, pcm_r;

  int unsigned total = 0, bad = 0, cyc = 0;
  int unsigned n_valid = 0, n_err = 0, n_to = 0;

  always #5 clk = ~clk;

  i2s_rx_deserializer #(
    .DATA_W(DW), .LOCK_FRAMES(4), .MIN_SLOT(16), .MAX_SLOT(32), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk(clk), .reset(reset), .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk), .i2s_sd(i2s_sd),
    .pcm_valid(pcm_valid), .pcm_l(pcm_l), .pcm_r(pcm_r), .locked(locked),
    .frame_err(frame_err), .rx_timeout(rx_timeout)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected event timeline, in visible-cycle numbers
  typedef struct { int unsigned c; logic [DW-1:0] l; logic [DW-1:0] r; } vev_t;
  typedef struct { int unsigned c; logic v; } lk_t;
  vev_t        v_q[$];
  lk_t         lk_q[$];
  int unsigned e_q[$];
  int unsigned to_q[$];
  logic        exp_lk = 1'b0;

  // Slot-level reference state
  logic          m_bits[$];
  logic          m_lr_prev = 1'b0, m_search = 1'b1, m_locked = 1'b0;
  int unsigned   m_lock_cnt = 0, m_last_det = 0;
  logic [DW-1:0] m_hold = '0;

  task automatic model_reset();
    m_bits.delete();
    m_lr_prev = 1'b0; m_search = 1'b1; m_locked = 1'b0; m_lock_cnt = 0; m_hold = '0;
    v_q.delete(); lk_q.delete(); e_q.delete(); to_q.delete();
    exp_lk = 1'b0;
  endtask

  task automatic model_bit(input logic lr, input logic d, input int unsigned det);
    int unsigned   len, vis;
    logic [DW-1:0] w;
    vis = det + 1;
    m_last_det = det;
    m_bits.push_back(d);
    if (lr == m_lr_prev) return;
    len = (m_bits.size() > 63) ? 63 : m_bits.size();
    w = '0;
    for (int i = 0; i < DW; i++) w = {w[DW-2:0], (i < m_bits.size()) ? m_bits[i] : 1'b0};
    if (m_search) begin
      m_search = 1'b0;
    end else if (len < 16 || len > 32) begin
      e_q.push_back(vis);
      if (m_locked) lk_q.push_back('{vis, 1'b0});
      m_locked = 1'b0; m_lock_cnt = 0; m_search = 1'b1;
    end else if (!m_lr_prev) begin
      m_hold = w;
    end else begin
      if (m_lock_cnt < 4) m_lock_cnt++;
      if (m_lock_cnt == 4) begin
        if (!m_locked) lk_q.push_back('{vis, 1'b1});
        m_locked = 1'b1;
        v_q.push_back('{vis, m_hold, w});
      end
    end
    m_bits.delete();
    m_lr_prev = lr;
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input int unsigned n);
    i2s_bclk = 1'b0;
    repeat (n) tick();
  endtask

  // Drive one bit period; the rise becomes bclk_rise two syncs later.
  task automatic send_bit(input logic lr, input logic d);
    int unsigned lo;
    lo = $urandom_range(2, 3);
    i2s_bclk = 1'b0; i2s_lrclk = lr; i2s_sd = d;
    repeat (lo) tick();
    i2s_bclk = 1'b1;
    model_bit(lr, d, cyc + 2);
    repeat (2) tick();
  endtask

  // Philips framing: lrclk switches to the next channel on the slot's last bit.
  task automatic send_range(input logic ch, input logic [63:0] data, input int hi, input int lo);
    for (int j = hi; j >= lo; j--) send_bit((j == 0) ? ~ch : ch, data[j]);
  endtask

  task automatic send_slot(input logic ch, input int len, input logic [63:0] data);
    send_range(ch, data, len - 1, 0);
  endtask

  task automatic send_frame(input int len, input logic [63:0] l, input logic [63:0] r);
    send_slot(1'b0, len, l);
    send_slot(1'b1, len, r);
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_valid"}, pcm_valid, 0);
    check({pfx, "_pcm_l"}, pcm_l, 0);
    check({pfx, "_pcm_r"}, pcm_r, 0);
    check({pfx, "_locked"}, locked, 0);
    check({pfx, "_frame_err"}, frame_err, 0);
    check({pfx, "_rx_timeout"}, rx_timeout, 0);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      while (lk_q.size() > 0 && lk_q[0].c <= cyc) exp_lk = lk_q.pop_front().v;
      check("locked", locked, exp_lk);
      if (pcm_valid) begin
        vev_t ev;
        n_valid++;
        if (v_q.size() == 0) check("valid_unexpected", 1, 0);
        else begin
          ev = v_q.pop_front();
          check("valid_cycle", cyc, ev.c);
          check("pcm_l", pcm_l, ev.l);
          check("pcm_r", pcm_r, ev.r);
        end
      end else if (v_q.size() > 0 && v_q[0].c < cyc) begin
        check("valid_missing", 0, 1);
        void'(v_q.pop_front());
      end
      if (frame_err) begin
        n_err++;
        if (e_q.size() == 0) check("err_unexpected", 1, 0);
        else check("err_cycle", cyc, e_q.pop_front());
      end else if (e_q.size() > 0 && e_q[0] < cyc) begin
        check("err_missing", 0, 1);
        void'(e_q.pop_front());
      end
      if (rx_timeout) begin
        n_to++;
        if (to_q.size() == 0) check("timeout_unexpected", 1, 0);
        else check("timeout_cycle", cyc, to_q.pop_front());
      end else if (to_q.size() > 0 && to_q[0] < cyc) begin
        check("timeout_missing", 0, 1);
        void'(to_q.pop_front());
      end
    end
  end

  initial begin
    int unsigned v0, e0, t0, len;
    logic [63:0] dl;

    reset = 1'b1;
    repeat (3) tick();
    check_zero("reset");
    reset = 1'b0;

    // Lock and data with 32-bit slots
    v0 = n_valid;
    repeat (6) send_frame(32, 64'h12345600, 64'hABCDEF00);
    idle(6);
    check("A_nvalid", n_valid - v0, 3);
    check("A_pcm_l", pcm_l, 24'h123456);
    check("A_pcm_r", pcm_r, 24'hABCDEF);
    check("A_locked", locked, 1);

    // Short slot after lock
    v0 = n_valid; e0 = n_err;
    send_slot(1'b0, 10, 64'h2A5);
    send_slot(1'b1, 32, 64'hABCDEF00);
    repeat (5) send_frame(32, 64'h12345600, 64'hABCDEF00);
    idle(6);
    check("B_nerr", n_err - e0, 1);
    check("B_nvalid", n_valid - v0, 2);
    check("B_locked", locked, 1);

    // Reset in the middle of a right slot
    send_slot(1'b0, 32, 64'h12345600);
    send_range(1'b1, 64'hABCDEF00, 31, 20);
    idle(4);
    reset = 1'b1;
    tick();
    check_zero("midrst");
    model_reset();
    reset = 1'b0;
    v0 = n_valid;
    send_range(1'b1, 64'hABCDEF00, 19, 0);
    repeat (5) send_frame(32, 64'h12345600, 64'hABCDEF00);
    idle(6);
    check("C_nvalid", n_valid - v0, 3);
    check("C_pcm_l", pcm_l, 24'h123456);
    check("C_locked", locked, 1);

    // 16-bit slots are MSB-justified and zero-padded
    v0 = n_valid;
    repeat (3) send_frame(16, 64'h8001, 64'h7FFF);
    idle(6);
    check("D_nvalid", n_valid - v0, 3);
    check("D_pcm_l", pcm_l, 24'h800100);
    check("D_pcm_r", pcm_r, 24'h7FFF00);

`ifdef KOSEI_I2S_RX_TIMEOUT_EN
    v0 = n_valid; t0 = n_to;
    to_q.push_back(m_last_det + TO_CYC);
    if (m_locked) lk_q.push_back('{m_last_det + TO_CYC, 1'b0});
    m_locked = 1'b0; m_lock_cnt = 0; m_search = 1'b1; m_bits.delete();
    idle(TO_CYC + 100);
    check("T_nto", n_to - t0, 1);
    check("T_locked", locked, 0);
    repeat (5) send_frame(32, 64'h12345600, 64'hABCDEF00);
    idle(6);
    check("T_nvalid", n_valid - v0, 2);
    check("T_relocked", locked, 1);
`else
    t0 = 0;
`endif

    // Random slot lengths and data, with occasional illegal slots
    for (int f = 0; f < 200; f++) begin
      for (int ch = 0; ch < 2; ch++) begin
        if ($urandom_range(0, 29) == 0)
          len = ($urandom_range(0, 1) == 0) ? $urandom_range(4, 15) : $urandom_range(33, 40);
        else
          len = $urandom_range(16, 32);
        dl = {$urandom, $urandom};
        send_slot(ch[0], int'(len), dl);
      end
    end
    idle(8);
    check("pending_valid", v_q.size(), 0);
    check("pending_err", e_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
